cordic_angle_reducer: RTL and testbench
=======================================

# cordic_angle_reducer

Parametrised, handshaked range-reduction front end for the CORDIC rotation core. Accepts a signed fixed-point angle of any magnitude representable in `IN_W` bits. Reduces it modulo 2π with an iterative shift-subtract sequence, then folds the result into [0, π/2]. Emits the folded angle, quadrant and cos/sin negate flags to the CORDIC pipeline over a valid/ready handshake.

## Interface
Parameters:
- `IN_W`, default 24: signed input width in two's complement. Constraint: `IN_W >= FRAC_BITS+4`.
- `OUT_W`, default 16: unsigned reduced-angle width. Constraint: `OUT_W >= FRAC_BITS+1`.
- `FRAC_BITS`, default 14: fractional bits of both input and output angle. Constraint: `FRAC_BITS <= 30`.

Ports:
- `Clk` in 1: single clock. All state changes on rising edge.
- `Rst_n` in 1: reset, synchronous and active-low.
- `In_valid` in 1: `Input_angle` valid.
- `In_ready` out 1: block can accept an input.
- `Input_angle` in `IN_W`: signed angle, Q(`IN_W-FRAC_BITS`).`FRAC_BITS`.
- `Out_valid` out 1: outputs valid.
- `Out_ready` in 1: downstream accepts outputs.
- `Reduced_angle` out `OUT_W`: folded angle in [0, π/2], same LSB weight as input.
- `Quadrant` out 2: quadrant of the reduced-mod-2π magnitude, 0..3.
- `Cos_negate` out 1: negate the CORDIC cos result.
- `Sin_negate` out 1: negate the CORDIC sin result.

## Operation
- Constants, LSB = 2^-FRAC_BITS:
  - TWO_PI = round(0x1921FB544 / 2^(30-FRAC_BITS)); at the default this is 0x19220.
  - PI = TWO_PI>>1. PI_2 = TWO_PI>>2. PI_3_2 = PI+PI_2.
- K_MAX = IN_W-FRAC_BITS-4. There are K_MAX+1 reduction steps (7 at default).
- FSM states:
  - IDLE: `In_ready`=1. On `In_valid`&&`In_ready`, capture neg = `Input_angle[IN_W-1]` and mag = |`Input_angle`| as `IN_W`-bit unsigned (the most negative value maps to 2^(IN_W-1); no overflow). Set k=K_MAX and go to REDUCE.
  - REDUCE: one step per cycle: if mag >= TWO_PI<<k then mag -= TWO_PI<<k. When k==0, go to FOLD; otherwise k--. On exit, mag is in [0, TWO_PI).
  - FOLD: apply the fold rules below, register all outputs, go to DONE.
  - DONE: `Out_valid`=1 and outputs held stable. On `Out_ready`, go to IDLE.
- `In_ready` is asserted only in IDLE. There is no accept in the same cycle as an output is taken.
- Fold rules, with r = reduced mag:
  - r < PI_2: angle r, Q0, cos/sin negate 0/0.
  - r < PI: angle PI-r, Q1, 1/0.
  - r < PI_3_2: angle r-PI, Q2, 1/1.
  - otherwise: angle TWO_PI-r, Q3, 0/1.
- Boundaries use strict <. So r==PI_2 gives Q1 with angle PI_2, and r==PI gives Q2 with angle 0.
- Negative input: `Sin_negate` ^= neg. `Cos_negate` and `Quadrant` are unchanged, because the quadrant describes the magnitude.
- `Reduced_angle` is zero-extended to `OUT_W`. The result is always <= PI_2, so it never truncates.

## Timing
- Reset (`Rst_n`=0 at a rising edge), in any state:
  - state goes to IDLE; `Out_valid`, `Reduced_angle`, `Quadrant`, `Cos_negate`, `Sin_negate` all go to 0.
  - `In_ready` reads 1 from the first reset edge.
  - Reset mid-REDUCE or in DONE discards the transaction.
- Latency: input accepted at edge E; `Out_valid` rises after edge E+K_MAX+2 (E+8 at default).
- Throughput: one result per K_MAX+4 cycles minimum when `Out_ready` is held at 1.
- Output stability: while `Out_valid`=1 and `Out_ready`=0, all outputs stay constant. `In_valid` is ignored outside IDLE.
- `Input_angle` is sampled only at the accept edge and may change afterwards.

## Structure
- Shared package `cordic_pkg`:
  - constant TWO_PI_Q30 = 33'h1921FB544;
  - function `angle_const(frac_bits)` returning the rounded TWO_PI;
  - quadrant enum Q0..Q3.
  - `cordic_pkg` is shared with the rotation core.
- One sub-module, `cordic_quadrant_fold`: combinational, mag/neg in → angle/quadrant/flags out, used in FOLD.
- The FSM, magnitude register and step counter live in the top level.

## Test plan
Defaults throughout (`IN_W`=24, `FRAC_BITS`=14):
- `Input_angle`=0x003000 → `Reduced_angle`=0x3000, Q0, cos/sin 0/0, `Out_valid` exactly 8 cycles after accept.
- 0x00C910 (π) → angle 0x0000, Q2, 1/1. 0x006488 (π/2) → angle 0x6488, Q1, 1/0.
- 0x07EAA0 (5·2π+0x1000) → angle 0x1000, Q0, 0/0. 0x019220 → angle 0, Q0, 0/0.
- 0xFFF000 (-0x1000) → angle 0x1000, Q0, 0/1. 0x800000 (most negative) → mag mod 2π = 0xC3E0 → angle 0x0530, Q1, 1/1.
- Hold `Out_ready`=0 for 5 cycles in DONE with `In_valid`=1 → outputs stable, `In_ready`=0, no second accept. Then release `Out_ready` → IDLE.
- Drop `Rst_n` for one edge mid-REDUCE → next cycle `Out_valid`=0, all outputs 0, `In_ready`=1. A following input completes normally.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: the 2*pi constant in Q30, its rounded rescale to any
// fractional width, the quadrant encoding and the range-reducer FSM states.
package cordic_pkg;

    localparam logic [32:0] TWO_PI_Q30 = 33'h1921FB544;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quadrant_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_FOLD   = 2'd2,
        ST_DONE   = 2'd3
    } fsm_state_e;

    // 2*pi with LSB = 2^-frac_bits, rounded half-up from the Q30 constant.
    function automatic logic [32:0] angle_const(input int frac_bits);
        logic [33:0] acc;
        if (frac_bits >= 30) begin
            return TWO_PI_Q30;
        end
        acc = {1'b0, TWO_PI_Q30} + (34'd1 << (29 - frac_bits));
        acc = acc >> (30 - frac_bits);
        return acc[32:0];
    endfunction

endpackage

// File: rtl/cordic_angle_reducer_if.sv
// Input/output bundle between the angle source, the range reducer and the CORDIC core.
interface cordic_angle_reducer_if #(
    parameter int IN_W  = 24,
    parameter int OUT_W = 16
);

    // Valid/ready: a transfer happens on a rising clock edge where valid and ready
    // are both 1; the sender holds valid and its payload stable until that edge.
    logic              In_valid;
    logic              In_ready;
    logic [IN_W-1:0]   Input_angle;
    logic              Out_valid;
    logic              Out_ready;
    logic [OUT_W-1:0]  Reduced_angle;
    logic [1:0]        Quadrant;
    logic              Cos_negate;
    logic              Sin_negate;

    modport master (
        output In_valid, Input_angle, Out_ready,
        input  In_ready, Out_valid, Reduced_angle, Quadrant, Cos_negate, Sin_negate
    );

    modport slave (
        input  In_valid, Input_angle, Out_ready,
        output In_ready, Out_valid, Reduced_angle, Quadrant, Cos_negate, Sin_negate
    );

endinterface

// File: rtl/cordic_quadrant_fold.sv
// Folds a magnitude already reduced into [0, 2*pi) onto [0, pi/2] and derives
// the quadrant and the cos/sin negate flags for the rotation core.
module cordic_quadrant_fold
    import cordic_pkg::*;
#(
    parameter int MAG_W     = 24,
    parameter int OUT_W     = 16,
    parameter int FRAC_BITS = 14
) (
    input  logic [MAG_W-1:0] mag,
    input  logic             neg,
    output logic [OUT_W-1:0] angle,
    output quadrant_e        quadrant,
    output logic             cos_negate,
    output logic             sin_negate
);

    localparam int W = (MAG_W > OUT_W) ? MAG_W : OUT_W;
    localparam logic [W-1:0] TWO_PI = W'(angle_const(FRAC_BITS));
    localparam logic [W-1:0] PI     = TWO_PI >> 1;
    localparam logic [W-1:0] PI_2   = TWO_PI >> 2;
    localparam logic [W-1:0] PI_3_2 = PI + PI_2;

    logic [W-1:0] r;
    logic         sin_base;

    assign r = W'(mag);

    // Strict < at every boundary, so pi/2 lands in Q1 and pi lands in Q2.
    always_comb begin
        angle      = '0;
        quadrant   = Q0;
        cos_negate = 1'b0;
        sin_base   = 1'b0;
        if (r < PI_2) begin
            angle = OUT_W'(r);
        end else if (r < PI) begin
            angle      = OUT_W'(PI - r);
            quadrant   = Q1;
            cos_negate = 1'b1;
        end else if (r < PI_3_2) begin
            angle      = OUT_W'(r - PI);
            quadrant   = Q2;
            cos_negate = 1'b1;
            sin_base   = 1'b1;
        end else begin
            angle      = OUT_W'(TWO_PI - r);
            quadrant   = Q3;
            sin_base   = 1'b1;
        end
        // sin is odd in the angle; the quadrant still describes the magnitude.
        sin_negate = sin_base ^ neg;
    end

endmodule

// File: rtl/cordic_angle_reducer.sv
// Range-reduction front end: |angle| mod 2*pi by shift-subtract, one step per cycle,
// then a quadrant fold; results are held on a valid/ready output until taken.
module cordic_angle_reducer
    import cordic_pkg::*;
#(
    parameter int IN_W      = 24,
    parameter int OUT_W     = 16,
    parameter int FRAC_BITS = 14
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    cordic_angle_reducer_if.slave  bus,
    output fsm_state_e             dbg_state
);

    localparam int K_MAX = IN_W - FRAC_BITS - 4;
    localparam int K_W   = (K_MAX < 1) ? 1 : $clog2(K_MAX + 1);

    localparam logic [32:0]     TWO_PI_C = angle_const(FRAC_BITS);
    localparam logic [IN_W-1:0] TWO_PI   = IN_W'(TWO_PI_C);
    localparam logic [K_W-1:0]  K_INIT   = K_W'(K_MAX);
    localparam logic [K_W-1:0]  K_ONE    = K_W'(1);

    fsm_state_e       state, state_next;
    logic [IN_W-1:0]  mag, mag_next;
    logic [K_W-1:0]   k, k_next;
    logic             neg, neg_next;
    logic             load_out;
    logic [IN_W-1:0]  step_const;

    logic [OUT_W-1:0] angle_q;
    quadrant_e        quad_q;
    logic             cos_q;
    logic             sin_q;

    logic [OUT_W-1:0] fold_angle;
    quadrant_e        fold_quad;
    logic             fold_cos;
    logic             fold_sin;

    // TWO_PI << K_MAX stays below 2^(IN_W-1), so the shifted constant never overflows.
    assign step_const = TWO_PI << k;

    always_comb begin
        state_next = state;
        mag_next   = mag;
        k_next     = k;
        neg_next   = neg;
        load_out   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.In_valid) begin
                    neg_next   = bus.Input_angle[IN_W-1];
                    // Unsigned view of the negation maps the most negative code to 2^(IN_W-1).
                    mag_next   = bus.Input_angle[IN_W-1] ? -bus.Input_angle : bus.Input_angle;
                    k_next     = K_INIT;
                    state_next = ST_REDUCE;
                end
            end
            ST_REDUCE: begin
                if (mag >= step_const) begin
                    mag_next = mag - step_const;
                end
                if (k == '0) begin
                    state_next = ST_FOLD;
                end else begin
                    k_next = k - K_ONE;
                end
            end
            ST_FOLD: begin
                load_out   = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                if (bus.Out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state   <= ST_IDLE;
            mag     <= '0;
            k       <= '0;
            neg     <= 1'b0;
            angle_q <= '0;
            quad_q  <= Q0;
            cos_q   <= 1'b0;
            sin_q   <= 1'b0;
        end else begin
            state <= state_next;
            mag   <= mag_next;
            k     <= k_next;
            neg   <= neg_next;
            if (load_out) begin
                angle_q <= fold_angle;
                quad_q  <= fold_quad;
                cos_q   <= fold_cos;
                sin_q   <= fold_sin;
            end
        end
    end

    cordic_quadrant_fold #(
        .MAG_W     (IN_W),
        .OUT_W     (OUT_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_fold (
        .mag        (mag),
        .neg        (neg),
        .angle      (fold_angle),
        .quadrant   (fold_quad),
        .cos_negate (fold_cos),
        .sin_negate (fold_sin)
    );

    assign bus.In_ready      = (state == ST_IDLE);
    assign bus.Out_valid     = (state == ST_DONE);
    assign bus.Reduced_angle = angle_q;
    assign bus.Quadrant      = quad_q;
    assign bus.Cos_negate    = cos_q;
    assign bus.Sin_negate    = sin_q;
    assign dbg_state         = state;

endmodule

// File: tb/tb_cordic_angle_reducer.sv
// Directed bench for cordic_angle_reducer: hand-computed vectors go into a
// scoreboard queue, a negedge monitor pops and compares each taken result.
module tb_cordic_angle_reducer;
    import cordic_pkg::*;

    localparam int IN_W      = 24;
    localparam int OUT_W     = 16;
    localparam int FRAC_BITS = 14;
    localparam int NVEC      = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [19:0] exp_q[$];
    fsm_state_e dbg_state;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cordic_angle_reducer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    cordic_angle_reducer #(
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .FRAC_BITS (FRAC_BITS)
    ) dut (
        .Clk       (clk),
        .Rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    function automatic logic [19:0] pack(input logic [15:0] a, input logic [1:0] q,
                                         input logic c, input logic s);
        return {a, q, c, s};
    endfunction

    function automatic logic [19:0] dut_out();
        return {bus.Reduced_angle, bus.Quadrant, bus.Cos_negate, bus.Sin_negate};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Drives one angle, waits (bounded) for acceptance; acc_cyc is the accept edge index.
    task automatic send(input logic [23:0] angle, input logic [19:0] exp, input bit push,
                        output int acc_cyc);
        bit got;
        got = 1'b0;
        @(posedge clk);
        #1;
        bus.In_valid    = 1'b1;
        bus.Input_angle = angle;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.In_ready) begin
                got = 1'b1;
                break;
            end
        end
        check("accept", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (push) exp_q.push_back(exp);
        bus.In_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.Out_valid && bus.Out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got 0x%0h, want none", dut_out());
            end else begin
                check("result", 32'(dut_out()), 32'(exp_q.pop_front()));
            end
        end
    end

    logic [23:0] vec_in  [NVEC];
    logic [19:0] vec_exp [NVEC];

    initial begin
        int acc;
        bit found;

        vec_in[0]  = 24'h00C910; vec_exp[0]  = pack(16'h0000, 2'd2, 1'b1, 1'b1);
        vec_in[1]  = 24'h006488; vec_exp[1]  = pack(16'h6488, 2'd1, 1'b1, 1'b0);
        vec_in[2]  = 24'h07EAA0; vec_exp[2]  = pack(16'h1000, 2'd0, 1'b0, 1'b0);
        vec_in[3]  = 24'h019220; vec_exp[3]  = pack(16'h0000, 2'd0, 1'b0, 1'b0);
        vec_in[4]  = 24'hFFF000; vec_exp[4]  = pack(16'h1000, 2'd0, 1'b0, 1'b1);
        vec_in[5]  = 24'h800000; vec_exp[5]  = pack(16'h0530, 2'd1, 1'b1, 1'b1);
        vec_in[6]  = 24'hFF36F0; vec_exp[6]  = pack(16'h0000, 2'd2, 1'b1, 1'b0);
        vec_in[7]  = 24'h018220; vec_exp[7]  = pack(16'h1000, 2'd3, 1'b0, 1'b1);
        vec_in[8]  = 24'hFE7DE0; vec_exp[8]  = pack(16'h1000, 2'd3, 1'b0, 1'b0);
        vec_in[9]  = 24'h012D98; vec_exp[9]  = pack(16'h6488, 2'd3, 1'b0, 1'b1);
        vec_in[10] = 24'h012D97; vec_exp[10] = pack(16'h6487, 2'd2, 1'b1, 1'b1);

        bus.In_valid    = 1'b0;
        bus.Input_angle = '0;
        bus.Out_ready   = 1'b1;

        // Clock/reset
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(bus.In_ready), 32'd1);
        check("rst_out_valid", 32'(bus.Out_valid), 32'd0);
        check("rst_outputs", 32'(dut_out()), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // First result and its latency from the accept edge
        send(24'h003000, pack(16'h3000, 2'd0, 1'b0, 1'b0), 1'b1, acc);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.Out_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("latency", found ? 32'(cyc - acc) : 32'hFFFF_FFFF, 32'd8);
        drain();

        for (int v = 0; v < NVEC; v++) begin
            send(vec_in[v], vec_exp[v], 1'b1, acc);
            drain();
        end

        // Backpressure: held output, In_valid asserted but ignored
        @(posedge clk);
        #1 bus.Out_ready = 1'b0;
        send(24'h00C910, pack(16'h0000, 2'd2, 1'b1, 1'b1), 1'b1, acc);
        bus.In_valid    = 1'b1;
        bus.Input_angle = 24'h003000;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.Out_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("hold_reached", 32'(found), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.Out_valid), 32'd1);
            check("hold_in_ready", 32'(bus.In_ready), 32'd0);
            check("hold_outputs", 32'(dut_out()), 32'(pack(16'h0000, 2'd2, 1'b1, 1'b1)));
        end
        @(posedge clk);
        #1;
        bus.In_valid  = 1'b0;
        bus.Out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_in_ready", 32'(bus.In_ready), 32'd1);
        check("release_out_valid", 32'(bus.Out_valid), 32'd0);
        check("release_state", 32'(dbg_state), 32'(ST_IDLE));
        repeat (12) @(negedge clk);
        check("no_second_accept", 32'(exp_q.size()), 32'd0);

        // One-edge reset in the middle of REDUCE
        send(24'h07EAA0, 20'd0, 1'b0, acc);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(bus.Out_valid), 32'd0);
        check("mid_rst_outputs", 32'(dut_out()), 32'd0);
        check("mid_rst_in_ready", 32'(bus.In_ready), 32'd1);
        check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        repeat (12) @(negedge clk);
        send(24'hFFF000, pack(16'h1000, 2'd0, 1'b0, 1'b1), 1'b1, acc);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
